// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, response payload
// and byte-lane sizing for the default 32-bit data path.
package apb_pkg;

  localparam int APB_MAX_DATA_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STRB_WIDTH         = DEFAULT_DATA_WIDTH / 8;
  localparam int ALIGN_BITS         = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // rdata is sized for the widest legal bus; narrower buses use the low lanes
  typedef struct packed {
    logic [APB_MAX_DATA_WIDTH-1:0] rdata;
    logic                          err;
    logic                          timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready; expired flags the wait cycle
// that brings the count up to the limit.
module apb_wait_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  // Combinational so the FSM can leave ACCESS on the very edge the count hits the limit
  assign expired = enable && (count_q == (limit - CNT_WIDTH'(1)));

endmodule

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: turns a command into one SETUP/ACCESS
// transfer, with alignment checking and a bounded wait for pready.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata,
  output apb_state_e              dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready,
  // a response on a rising edge with rsp_valid && rsp_ready; valid never waits on ready.
  apb_state_e state_q, state_d;
  apb_rsp_t   rsp_q;
  logic       accept, aligned;
  logic       timer_clr, timer_en, timer_expired;

  assign aligned = (cmd_addr & ALIGN_MASK) == '0;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = aligned ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        timer_clr = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d = ST_RESP;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  apb_wait_timer #(.CNT_WIDTH(8)) u_wait_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (timer_clr),
    .enable  (timer_en),
    .limit   (TIMEOUT_LIMIT),
    .expired (timer_expired)
  );

  // Request fields are only loaded on accept, so they hold through SETUP and ACCESS
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (accept && aligned) begin
      paddr  <= cmd_addr;
      pwrite <= cmd_write;
      pwdata <= cmd_write ? cmd_wdata : '0;
      pstrb  <= cmd_write ? cmd_strb : '0;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_q <= '0;
    end else if (accept && !aligned) begin
      rsp_q.rdata   <= '0;
      rsp_q.err     <= 1'b1;
      rsp_q.timeout <= 1'b0;
    end else if (state_q == ST_ACCESS && pready) begin
      rsp_q.rdata   <= (pwrite || pslverr) ? '0 : APB_MAX_DATA_WIDTH'(prdata);
      rsp_q.err     <= pslverr;
      rsp_q.timeout <= 1'b0;
    end else if (state_q == ST_ACCESS && timer_expired) begin
      rsp_q.rdata   <= '0;
      rsp_q.err     <= 1'b0;
      rsp_q.timeout <= 1'b1;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: vector table of commands against a scripted completer,
// with an expected-response queue checked at each response handshake.
module tb_apb_requester;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;
  apb_state_e  dbg_state;

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check_eq("rsp_payload", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(e));
      end
    end
  end

  // vector table
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
    int          exp_psel;
  } vec_t;

  vec_t vecs[12];

  // driver
  task automatic run_vec(input vec_t v);
    int budget, acc, psel_cnt, lat;
    logic hold_bad, stable_bad, seen;
    logic [33:0] snap;
    budget = 0;
    while (!cmd_ready && budget < 50) begin
      @(posedge pclk); #1;
      budget++;
    end
    check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    pready    = 1'($urandom_range(0, 1));
    pslverr   = 1'($urandom_range(0, 1));
    exp_q.push_back({v.exp_rdata, v.exp_err, v.exp_to});
    lat = cyc;
    acc = 0; psel_cnt = 0; hold_bad = 1'b0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge pclk); #1;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom_range(0, 15));
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (psel) begin
          psel_cnt++;
          if (paddr !== v.addr || pwrite !== v.write ||
              pwdata !== (v.write ? v.wdata : 32'h0) ||
              pstrb !== (v.write ? v.strb : 4'h0)) hold_bad = 1'b1;
        end
        if (penable) begin
          pready  = (acc == v.waits);
          prdata  = (acc == v.waits) ? v.prdata : $urandom;
          pslverr = v.slverr;
          acc++;
        end else begin
          pready  = 1'($urandom_range(0, 1));
          pslverr = 1'($urandom_range(0, 1));
          prdata  = $urandom;
        end
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    pready = 1'b0;
    rsp_ready = 1'b0;
    lat = seen ? (cyc - lat) : -1;
    check_eq("latency", 64'(lat), 64'(v.exp_lat));
    check_eq("psel_cycles", 64'(psel_cnt), 64'(v.exp_psel));
    if (v.exp_psel > 0) check_eq("apb_hold", 64'(hold_bad), 64'd0);
    snap = {rsp_rdata, rsp_err, rsp_timeout};
    stable_bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge pclk); #1;
      if (!rsp_valid || {rsp_rdata, rsp_err, rsp_timeout} !== snap) stable_bad = 1'b1;
    end
    if (v.hold > 0) check_eq("rsp_stable", 64'(stable_bad), 64'd0);
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    check_eq("post_handshake", 64'({cmd_ready, rsp_valid, psel}), 64'(3'b100));
  endtask

  initial begin
    logic idle_bad;
    vecs[0]  = '{1'b0, 32'h4,        32'h0,        4'h0, 0,  32'hCAFEF00D, 1'b0, 0, 32'hCAFEF00D, 1'b0, 1'b0, 3,  2};
    vecs[1]  = '{1'b1, 32'h8,        32'hDEADBEEF, 4'hF, 3,  32'h12345678, 1'b0, 1, 32'h0,        1'b0, 1'b0, 6,  5};
    vecs[2]  = '{1'b0, 32'h3,        32'h0,        4'h0, 0,  32'h11111111, 1'b0, 0, 32'h0,        1'b1, 1'b0, 1,  0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'h0, 99, 32'h22222222, 1'b0, 0, 32'h0,        1'b0, 1'b1, 18, 17};
    vecs[4]  = '{1'b0, 32'h14,       32'h0,        4'h0, 15, 32'h0A5A5A5A, 1'b0, 2, 32'h0A5A5A5A, 1'b0, 1'b0, 18, 17};
    vecs[5]  = '{1'b0, 32'h20,       32'h0,        4'h0, 1,  32'h13572468, 1'b0, 5, 32'h13572468, 1'b0, 1'b0, 4,  3};
    vecs[6]  = '{1'b1, 32'h24,       32'h55AA55AA, 4'h5, 0,  32'h99999999, 1'b0, 0, 32'h0,        1'b0, 1'b0, 3,  2};
    vecs[7]  = '{1'b0, 32'h28,       32'h0,        4'h0, 2,  32'h0,        1'b1, 1, 32'h0,        1'b1, 1'b0, 5,  4};
    vecs[8]  = '{1'b1, 32'h6,        32'h01020304, 4'h3, 0,  32'h0,        1'b0, 0, 32'h0,        1'b1, 1'b0, 1,  0};
    vecs[9]  = '{1'b1, 32'h30,       32'hA5A5A5A5, 4'hC, 99, 32'h0,        1'b1, 0, 32'h0,        1'b0, 1'b1, 18, 17};
    vecs[10] = '{1'b1, 32'h3C,       32'hFEEDFACE, 4'h8, 2,  32'hBBBBBBBB, 1'b1, 0, 32'h0,        1'b1, 1'b0, 5,  4};
    vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 4,  32'h87654321, 1'b0, 3, 32'h87654321, 1'b0, 1'b0, 7,  6};

    // reset values, during and after reset
    #12;
    check_eq("reset_ctrl", 64'({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}),
             64'(7'b1000000));
    check_eq("reset_data", 64'({paddr, pwdata}), 64'd0);
    check_eq("reset_strb_rdata", 64'({pstrb, rsp_rdata}), 64'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    check_eq("idle_after_reset", 64'({cmd_ready, psel, rsp_valid}), 64'(3'b100));
    check_eq("dbg_state_idle", 64'(dbg_state), 64'(ST_IDLE));

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // reset pulsed in the middle of ACCESS aborts the transfer silently
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !penable; k++) begin
      pready = 1'b0;
      @(posedge pclk); #1;
    end
    pready = 1'b0;
    check_eq("reached_access", 64'(penable), 64'd1);
    @(posedge pclk); #1;
    #2 preset = 1'b1;
    #1;
    check_eq("reset_midxfer", 64'({psel, penable, rsp_valid, cmd_ready}), 64'(4'b0001));
    @(posedge pclk); #1;
    preset = 1'b0;
    idle_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rsp_ready = 1'b1;
      pready = 1'b1;
      @(posedge pclk); #1;
      if (rsp_valid || psel || !cmd_ready) idle_bad = 1'b1;
    end
    rsp_ready = 1'b0;
    pready = 1'b0;
    check_eq("no_rsp_after_abort", 64'(idle_bad), 64'd0);
    run_vec(vecs[0]);

    repeat (3) @(posedge pclk);
    #1;
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
